// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: owner and state
// encodings, the fetch access type and the load/store type width.
package mem_port_arbiter_pkg;

    localparam int LSB_TYPE_WIDTH   = 4;
    localparam int STARVE_CNT_WIDTH = 4;

    // Fetches always go out as an unsigned word read with no write data.
    localparam logic [LSB_TYPE_WIDTH-1:0] FETCH_TYPE = 4'b0010;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester handshakes and the memory controller port.
// The slave modport is the arbiter's view; the master modport is the
// surrounding environment (fetch unit, load/store buffer, controller).
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                      if_en;
    logic [31:0]               if_addr;
    logic                      if_rdy;
    logic [31:0]               if_data;

    logic                      ld_en;
    logic [31:0]               ld_addr;
    logic [LSB_TYPE_WIDTH-1:0] ld_type;
    logic                      ld_rdy;
    logic [31:0]               ld_data;

    logic                      st_en;
    logic [31:0]               st_addr;
    logic [LSB_TYPE_WIDTH-1:0] st_type;
    logic [31:0]               st_wdata;
    logic                      st_rdy;

    logic                      mc_en;
    logic [31:0]               mc_addr;
    logic [LSB_TYPE_WIDTH-1:0] mc_type;
    logic [31:0]               mc_wdata;
    logic                      mc_rdy;
    logic [31:0]               mc_rdata;

    modport slave (
        input  if_en, if_addr,
        output if_rdy, if_data,
        input  ld_en, ld_addr, ld_type,
        output ld_rdy, ld_data,
        input  st_en, st_addr, st_type, st_wdata,
        output st_rdy,
        output mc_en, mc_addr, mc_type, mc_wdata,
        input  mc_rdy, mc_rdata
    );

    modport master (
        output if_en, if_addr,
        input  if_rdy, if_data,
        output ld_en, ld_addr, ld_type,
        input  ld_rdy, ld_data,
        output st_en, st_addr, st_type, st_wdata,
        input  st_rdy,
        input  mc_en, mc_addr, mc_type, mc_wdata,
        output mc_rdy, mc_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive load/store grants taken while a fetch
// was waiting. hit goes high once the count reaches LIMIT.
module mem_arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_V = STARVE_CNT_WIDTH'(LIMIT);

    logic [STARVE_CNT_WIDTH-1:0] cnt_q;

    // Count up to the limit and stick there; clear wins over increment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else if (en) begin
            if (clr) begin
                cnt_q <= '0;
            end else if (inc && (cnt_q != LIMIT_V)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign hit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory controller's single load/store port between fetch,
// load and store. Fixed priority store > load > fetch; when
// MEM_ARB_STARVE_GUARD_EN is defined a fetch that has watched STARVE_LIMIT
// consecutive load/store grants is forced to win the next arbitration.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | no request outstanding; arbitrate and latch the winner
//  GRANT   | mc_* held steady until the controller pulses mc_rdy
//  RELEASE | one dead cycle so the finished requester can drop its request
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush,
    output logic              busy,
    mem_port_arbiter_if.slave bus
);

    arb_state_e                state_q;
    arb_state_e                state_d;
    owner_e                    owner_q;
    owner_e                    pick;
    logic                      mc_en_q;
    logic [31:0]               mc_addr_q;
    logic [LSB_TYPE_WIDTH-1:0] mc_type_q;
    logic [31:0]               mc_wdata_q;
    logic [31:0]               sel_addr;
    logic [LSB_TYPE_WIDTH-1:0] sel_type;
    logic [31:0]               sel_wdata;
    logic                      flush_act;
    logic                      starve_hit;
    logic                      force_if;

    assign flush_act = flush & rdy_in;
    assign force_if  = starve_hit & bus.if_en;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic starve_clr;
    logic starve_inc;

    assign starve_clr = flush_act
                      | ((state_q == ST_IDLE) & (~bus.if_en | (pick == OWN_IF)));
    assign starve_inc = (state_q == ST_IDLE) & bus.if_en
                      & ((pick == OWN_LD) | (pick == OWN_ST));

    mem_arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en       (rdy_in),
        .clr      (starve_clr),
        .inc      (starve_inc),
        .hit      (starve_hit)
    );
`else
    // Guard not built: fetch only wins when nothing else asks. The limit
    // appears here only so both builds share one parameter list.
    assign starve_hit = 1'b0 & (STARVE_LIMIT != 0);
`endif

    // Arbitration winner and the request fields it would present.
    always_comb begin
        pick      = OWN_NONE;
        sel_addr  = '0;
        sel_type  = '0;
        sel_wdata = '0;
        if (force_if) begin
            pick = OWN_IF;
        end else if (bus.st_en) begin
            pick = OWN_ST;
        end else if (bus.ld_en) begin
            pick = OWN_LD;
        end else if (bus.if_en) begin
            pick = OWN_IF;
        end
        case (pick)
            OWN_IF: begin
                sel_addr = bus.if_addr;
                sel_type = FETCH_TYPE;
            end
            OWN_LD: begin
                sel_addr = bus.ld_addr;
                sel_type = bus.ld_type;
            end
            OWN_ST: begin
                sel_addr  = bus.st_addr;
                sel_type  = bus.st_type;
                sel_wdata = bus.st_wdata;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; nothing advances while rdy_in is low.
    always_comb begin
        state_d = state_q;
        if (flush_act) begin
            state_d = ST_IDLE;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE:    if (pick != OWN_NONE) state_d = ST_GRANT;
                ST_GRANT:   if (bus.mc_rdy)       state_d = ST_RELEASE;
                ST_RELEASE: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Controller request registers and owner; owner drops on leaving GRANT
    // so a late mc_rdy cannot reach a requester.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mc_en_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_type_q  <= '0;
            mc_wdata_q <= '0;
            owner_q    <= OWN_NONE;
        end else if (flush_act) begin
            mc_en_q <= 1'b0;
            owner_q <= OWN_NONE;
        end else if (rdy_in) begin
            if ((state_q == ST_IDLE) && (pick != OWN_NONE)) begin
                mc_en_q    <= 1'b1;
                mc_addr_q  <= sel_addr;
                mc_type_q  <= sel_type;
                mc_wdata_q <= sel_wdata;
                owner_q    <= pick;
            end else if ((state_q == ST_GRANT) && bus.mc_rdy) begin
                mc_en_q <= 1'b0;
                owner_q <= OWN_NONE;
            end
        end
    end

    // Upstream done pulses and data routing, combinational from mc_rdy.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        bus.if_rdy  = bus.mc_rdy & (owner_q == OWN_IF) & ~flush_act;
        bus.ld_rdy  = bus.mc_rdy & (owner_q == OWN_LD) & ~flush_act;
        bus.st_rdy  = bus.mc_rdy & (owner_q == OWN_ST) & ~flush_act;
        bus.if_data = bus.mc_rdata;
        bus.ld_data = bus.mc_rdata;
    end

    assign bus.mc_en    = mc_en_q;
    assign bus.mc_addr  = mc_addr_q;
    assign bus.mc_type  = mc_type_q;
    assign bus.mc_wdata = mc_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter with STARVE_LIMIT=2.
// The reference model tracks pending requests per requester and a count of
// consecutive load/store wins while fetch waits.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int W_NONE = 0;
    localparam int W_IF   = 1;
    localparam int W_LD   = 2;
    localparam int W_ST   = 3;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b0;
    logic flush    = 1'b0;
    logic busy;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    bit          p_if, p_ld, p_st;
    logic [31:0] a_if, a_ld, a_st, wd_st;
    logic [3:0]  t_ld, t_st;
    int          streak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_reqs();
        bus.if_en    = p_if;
        bus.if_addr  = a_if;
        bus.ld_en    = p_ld;
        bus.ld_addr  = a_ld;
        bus.ld_type  = t_ld;
        bus.st_en    = p_st;
        bus.st_addr  = a_st;
        bus.st_type  = t_st;
        bus.st_wdata = wd_st;
    endtask

    task automatic new_req(input int which);
        case (which)
            W_IF: begin
                a_if = {4'h1, 26'($urandom), 2'b00};
                p_if = 1'b1;
            end
            W_LD: begin
                a_ld = {4'h2, 28'($urandom)};
                t_ld = {1'b0, 3'($urandom)};
                p_ld = 1'b1;
            end
            W_ST: begin
                a_st  = {4'h3, 28'($urandom)};
                t_st  = {1'b1, 3'($urandom)};
                wd_st = $urandom;
                p_st  = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Winner by the arbitration rules: fetch forced after LIMIT ld/st wins
    // while it waited (guard builds only), else store > load > fetch.
    function automatic int model_pick();
        if (GUARD && p_if && (streak == LIMIT)) return W_IF;
        if (p_st) return W_ST;
        if (p_ld) return W_LD;
        if (p_if) return W_IF;
        return W_NONE;
    endfunction

    function automatic void model_commit(input int w);
        if ((w == W_IF) || !p_if) streak = 0;
        else if ((w != W_NONE) && (streak < LIMIT)) streak = streak + 1;
    endfunction

    // Entered in IDLE with requests driven; leaves the DUT back in IDLE.
    task automatic serve(input int lat, input logic [31:0] rdata, input int exp_w);
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  et;
        ea = 32'h0; ew = 32'h0; et = 4'h0;
        case (exp_w)
            W_IF: begin ea = a_if; et = 4'b0010; end
            W_LD: begin ea = a_ld; et = t_ld; end
            W_ST: begin ea = a_st; et = t_st; ew = wd_st; end
            default: ;
        endcase
        model_commit(exp_w);
        tick();
        chk("grant_mc_en", 32'(bus.mc_en), 32'h1);
        chk("grant_busy", 32'(busy), 32'h1);
        chk("grant_addr", bus.mc_addr, ea);
        chk("grant_type", 32'(bus.mc_type), 32'(et));
        if (exp_w != W_LD) chk("grant_wdata", bus.mc_wdata, ew);
        for (int k = 0; k < lat; k++) begin
            tick();
            chk("hold_mc_en", 32'(bus.mc_en), 32'h1);
            chk("hold_addr", bus.mc_addr, ea);
        end
        bus.mc_rdy   = 1'b1;
        bus.mc_rdata = rdata;
        #1;
        chk("if_rdy", 32'(bus.if_rdy), 32'(exp_w == W_IF));
        chk("ld_rdy", 32'(bus.ld_rdy), 32'(exp_w == W_LD));
        chk("st_rdy", 32'(bus.st_rdy), 32'(exp_w == W_ST));
        if (exp_w == W_IF) chk("if_data", bus.if_data, rdata);
        if (exp_w == W_LD) chk("ld_data", bus.ld_data, rdata);
        tick();
        bus.mc_rdy = 1'b0;
        case (exp_w)
            W_IF: p_if = 1'b0;
            W_LD: p_ld = 1'b0;
            W_ST: p_st = 1'b0;
            default: ;
        endcase
        drive_reqs();
        chk("release_mc_en", 32'(bus.mc_en), 32'h0);
        chk("release_busy", 32'(busy), 32'h1);
        bus.mc_rdy = 1'b1;
        #1;
        chk("release_no_rdy", 32'({bus.if_rdy, bus.ld_rdy, bus.st_rdy}), 32'h0);
        bus.mc_rdy = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_mc_en", 32'(bus.mc_en), 32'h0);
    endtask

    initial begin
        int w;
        p_if = 0; p_ld = 0; p_st = 0;
        a_if = 0; a_ld = 0; a_st = 0; wd_st = 0; t_ld = 0; t_st = 4'h8;
        drive_reqs();
        bus.mc_rdy   = 1'b0;
        bus.mc_rdata = 32'h0;

        // Reset values
        #12;
        chk("rst_mc_en", 32'(bus.mc_en), 32'h0);
        chk("rst_mc_addr", bus.mc_addr, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        rdy_in   = 1'b1;
        tick();

        // Single fetch, slow controller
        a_if = 32'h100; p_if = 1'b1;
        drive_reqs();
        serve(5, 32'hDEADBEEF, W_IF);

        // All three at once: store, load, fetch
        new_req(W_IF); new_req(W_LD); new_req(W_ST);
        drive_reqs();
        serve(1, $urandom, W_ST);
        serve(0, $urandom, W_LD);
        serve(2, $urandom, W_IF);

        // Fetch held while load/store keep re-requesting
        new_req(W_IF); new_req(W_LD); new_req(W_ST);
        drive_reqs();
        serve(0, $urandom, W_ST);
        new_req(W_ST); drive_reqs();
        serve(0, $urandom, W_ST);
        new_req(W_ST); drive_reqs();
        serve(0, $urandom, GUARD ? W_IF : W_ST);
        while (model_pick() != W_NONE) serve(0, $urandom, model_pick());

        // Flush during a load grant, then re-arbitration
        new_req(W_LD);
        drive_reqs();
        tick();
        chk("flush_pre_mc_en", 32'(bus.mc_en), 32'h1);
        chk("flush_pre_addr", bus.mc_addr, a_ld);
        flush = 1'b1;
        bus.mc_rdy = 1'b1;
        #1;
        chk("flush_no_ld_rdy", 32'(bus.ld_rdy), 32'h0);
        tick();
        flush = 1'b0;
        bus.mc_rdy = 1'b0;
        streak = 0;
        chk("flush_mc_en", 32'(bus.mc_en), 32'h0);
        chk("flush_busy", 32'(busy), 32'h0);
        serve(1, $urandom, W_LD);

        // Asynchronous reset in the middle of a store grant
        new_req(W_ST);
        drive_reqs();
        tick();
        chk("arst_pre_mc_en", 32'(bus.mc_en), 32'h1);
        #3;
        rst_n_in   = 1'b0;
        bus.mc_rdy = 1'b1;
        #1;
        chk("arst_mc_en", 32'(bus.mc_en), 32'h0);
        chk("arst_mc_addr", bus.mc_addr, 32'h0);
        chk("arst_mc_type", 32'(bus.mc_type), 32'h0);
        chk("arst_mc_wdata", bus.mc_wdata, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_st_rdy", 32'(bus.st_rdy), 32'h0);
        bus.mc_rdy = 1'b0;
        p_st = 1'b0;
        drive_reqs();
        streak = 0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();

        // Global ready low while a store waits in IDLE
        new_req(W_ST);
        drive_reqs();
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_mc_en", 32'(bus.mc_en), 32'h0);
            chk("stall_busy", 32'(busy), 32'h0);
        end
        rdy_in = 1'b1;
        serve(2, $urandom, W_ST);

        // Randomized request mix against the model
        for (int i = 0; i < 60; i++) begin
            if (!p_if && ($urandom_range(0, 3) != 0)) new_req(W_IF);
            if (!p_ld && ($urandom_range(0, 1) != 0)) new_req(W_LD);
            if (!p_st && ($urandom_range(0, 1) != 0)) new_req(W_ST);
            drive_reqs();
            if ($urandom_range(0, 4) == 0) begin
                rdy_in = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    tick();
                    chk("rnd_stall_mc_en", 32'(bus.mc_en), 32'h0);
                end
                rdy_in = 1'b1;
            end
            w = model_pick();
            if (w == W_NONE) begin
                model_commit(W_NONE);
                tick();
                chk("rnd_idle_mc_en", 32'(bus.mc_en), 32'h0);
                chk("rnd_idle_busy", 32'(busy), 32'h0);
            end else begin
                serve($urandom_range(0, 3), $urandom, w);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
